// File: rtl/odd_count_seq_if.sv
// Command channel between the host control block and the odd/even step sequencer.
// The host is the master; the sequencer is the slave and only returns cmd_ready.
interface odd_count_seq_if #(
    parameter int WIDTH  = 8,
    parameter int PASS_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_mode;
    logic [WIDTH-1:0]  cmd_limit;
    logic [PASS_W-1:0] cmd_repeat;

    modport master (
        output cmd_valid,
        output cmd_mode,
        output cmd_limit,
        output cmd_repeat,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_mode,
        input  cmd_limit,
        input  cmd_repeat,
        output cmd_ready
    );
endinterface

// File: rtl/odd_count_seq.sv
// Odd/even step-by-two counting sequencer with programmable passes, pause and abort.
// Reports completion with a one-cycle done pulse qualified by err.
module odd_count_seq #(
    parameter int WIDTH  = 8,
    parameter int PASS_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    odd_count_seq_if.slave    cmd,
    input  logic              pause,
    input  logic              abort,
    output logic [WIDTH-1:0]  cnt_o,
    output logic              cnt_valid,
    output logic [PASS_W-1:0] pass_cnt,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0]  CNT_STEP = WIDTH'(2);
    localparam logic [PASS_W-1:0] PASS_ONE = PASS_W'(1);

    state_t            state_r;
    logic              mode_r;
    logic [WIDTH-1:0]  eff_limit_r;
    logic [PASS_W-1:0] last_pass_r;
    logic [WIDTH-1:0]  cnt_r;
    logic              cnt_valid_r;
    logic [PASS_W-1:0] pass_r;
    logic              done_r;
    logic              err_r;

    logic [WIDTH-1:0]  eff_limit_s;
    logic              reject_s;
    logic              accept_s;
    logic [WIDTH-1:0]  start_s;
    logic              at_limit_s;
    logic              last_pass_s;

    // Parity-adjusted limit and rejection check for the command on the bus
    always_comb begin
        eff_limit_s = '0;
        reject_s    = 1'b0;
        if (cmd.cmd_mode) begin
            if (cmd.cmd_limit[0]) begin
                eff_limit_s = cmd.cmd_limit;
            end else if (cmd.cmd_limit == '0) begin
                // no odd value fits below a zero limit
                reject_s = 1'b1;
            end else begin
                eff_limit_s = cmd.cmd_limit - CNT_ONE;
            end
        end else begin
            eff_limit_s = {cmd.cmd_limit[WIDTH-1:1], 1'b0};
        end
    end

    // Handshake and run-time comparisons against the latched command
    always_comb begin
        accept_s    = cmd.cmd_valid && (state_r == ST_IDLE);
        start_s     = mode_r ? CNT_ONE : '0;
        at_limit_s  = (cnt_r == eff_limit_r);
        last_pass_s = (pass_r == last_pass_r);
    end

    // Sequencer FSM with all registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            mode_r      <= 1'b0;
            eff_limit_r <= '0;
            last_pass_r <= '0;
            cnt_r       <= '0;
            cnt_valid_r <= 1'b0;
            pass_r      <= '0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r      <= 1'b0;
                    err_r       <= 1'b0;
                    cnt_valid_r <= 1'b0;
                    if (accept_s) begin
                        mode_r      <= cmd.cmd_mode;
                        eff_limit_r <= eff_limit_s;
                        last_pass_r <= cmd.cmd_repeat;
                        if (reject_s) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            err_r   <= 1'b1;
                        end else begin
                            state_r     <= ST_RUN;
                            cnt_r       <= cmd.cmd_mode ? CNT_ONE : '0;
                            cnt_valid_r <= 1'b1;
                            pass_r      <= '0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_r     <= ST_DONE;
                        done_r      <= 1'b1;
                        err_r       <= 1'b1;
                        cnt_valid_r <= 1'b0;
                    end else if (pause) begin
                        cnt_valid_r <= 1'b0;
                    end else if (!at_limit_s) begin
                        // eff_limit_r shares parity with the start, so this never skips past it
                        cnt_r       <= cnt_r + CNT_STEP;
                        cnt_valid_r <= 1'b1;
                    end else if (!last_pass_s) begin
                        cnt_r       <= start_s;
                        pass_r      <= pass_r + PASS_ONE;
                        cnt_valid_r <= 1'b1;
                    end else begin
                        state_r     <= ST_DONE;
                        done_r      <= 1'b1;
                        err_r       <= 1'b0;
                        cnt_valid_r <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r     <= ST_IDLE;
                    done_r      <= 1'b0;
                    err_r       <= 1'b0;
                    cnt_valid_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    done_r      <= 1'b0;
                    err_r       <= 1'b0;
                    cnt_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign cmd.cmd_ready = (state_r == ST_IDLE);
    assign busy          = (state_r != ST_IDLE);
    assign cnt_o         = cnt_r;
    assign cnt_valid     = cnt_valid_r;
    assign pass_cnt      = pass_r;
    assign done          = done_r;
    assign err           = err_r;

endmodule
